matmul_axis_top: RTL and testbench
==================================

Name: matmul_axis_top

Overview:
- Output-stationary SIZE×SIZE systolic matrix multiplier computing C = A·B on signed fixed-point operands.
- Consumes one pre-skewed row-lane vector of A and one column-lane vector of B per valid cycle.
- Exposes the live C diagonal on o_c_diag_to_buffer.
- After completion, streams the full C matrix out over an AXI4-Stream master port (M00_AXIS).

Parameters:
- SIZE, 4: array dimension N_max; must be a power of two, at least 2.
- I_BITS, 8: signed operand width.
- O_BITS, 16: signed accumulator/result width; results saturate to this width.
- C_M00_AXIS_TDATA_WIDTH, 32: AXIS data width; must be at least O_BITS.

Ports:
- i_clock  in  1  sole clock for all logic.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  qualifies i_a_full/i_b_full; low = stall.
- i_a_full  in  I_BITS*SIZE  A lanes; lane r at [I_BITS*r +: I_BITS] feeds array row r.
- i_b_full  in  I_BITS*SIZE  B lanes; lane c at [I_BITS*c +: I_BITS] feeds array column c.
- rf_matrix_size  in  3  active size code N = 2^(code+1): 000=2, 001=4, 010=8; codes giving N>SIZE clamp to SIZE.
- o_c_diag_to_buffer  out  O_BITS*SIZE  lane k = C[k][k] accumulator.
- m00_axis_aclk  in  1  must be tied to i_clock; not used internally.
- m00_axis_aresetn  in  1  not used internally; i_reset governs the AXIS logic.
- m00_axis_tvalid  out  1  AXIS valid.
- m00_axis_tdata  out  C_M00_AXIS_TDATA_WIDTH  one C element, sign-extended.
- m00_axis_tstrb  out  C_M00_AXIS_TDATA_WIDTH/8  always all ones.
- m00_axis_tlast  out  1  high on the final beat.
- m00_axis_tready  in  1  AXIS ready.

Behaviour:
- Reset (synchronous, i_reset=1 at the clock edge):
  - Clears all PE accumulators, a/b forwarding registers, the valid-cycle counter and the AXIS FSM (state IDLE).
  - Resulting outputs: o_c_diag_to_buffer=0, tvalid=0, tlast=0, tdata=0.
  - Reset has priority over all other events, including mid-compute and mid-send.
- PE(r,c):
  - Operand a: i_a lane r directly when c=0, otherwise the registered a of PE(r,c-1).
  - Operand b: i_b lane c directly when r=0, otherwise the registered b of PE(r-1,c).
  - On a clock edge with i_valid=1 and state COMPUTE/IDLE: acc <= sat(acc + a*b), then a_reg <= a and b_reg <= b.
  - With i_valid=0: all registers hold.
- Arithmetic:
  - Product is signed, 2*I_BITS wide.
  - Sum is formed at O_BITS+1 bits, then saturated to [-2^(O_BITS-1), 2^(O_BITS-1)-1]. No wrap.
- Operand skew is external to this block: row r of A is delayed r cycles and column c of B is delayed c cycles by the source, with zeros padded.
- Active size N:
  - PEs with r≥N or c≥N have their accumulators forced to 0.
  - Diagonal lanes k≥N read 0.
- Valid-cycle counter:
  - Counts accepted valid cycles since reset.
  - When the count reaches 3N-2, state moves IDLE/COMPUTE → SEND and the array freezes; later i_valid is ignored.
  - The first accepted valid cycle moves IDLE → COMPUTE.
- SEND state:
  - tvalid=1; tdata = sign-extended C[i][j], row-major, beat index 0..N*N-1.
  - Index advances only on a tvalid&tready edge.
  - tdata/tlast remain stable while tready=0.
  - tlast=1 only on beat N*N-1.
  - After the last handshake → DONE: tvalid=0, results held, diagonal still visible, until i_reset.
- o_c_diag_to_buffer is driven from the registered accumulators. A product accepted at edge t appears on the diagonal after edge t, i.e. latency 1 cycle.
- rf_matrix_size is sampled continuously; changing it outside IDLE is unsupported, and the result in that case is don't-care.

Test Plan:
- N=4 (code 001), A=I, B all 3, properly skewed over 10 valid cycles → diag lanes 3,3,3,3; SEND emits 16 beats of 3 with tlast on beat 15.
- A = B = [[1,2,3,4]×4 rows], with tready held 1 → C[k][k] = 10·(k+1) (10,20,30,40), and the AXIS beat sequence matches row-major C.
- Saturation:
  - A all 127, B all 127 → every C = 32767 (raw 64516).
  - A all -128, B all 127 → every C = -32768.
- Stall and backpressure:
  - Insert i_valid=0 cycles mid-stream → diag identical to the unstalled run.
  - Toggle tready → tdata is held during stalls, no beat is lost or duplicated, tlast occurs exactly once.
- Code 000 (N=2) with SIZE=4, A=[[1,2],[3,4]], B=[[5,6],[7,8]] → diag lanes 19,50,0,0; exactly 4 beats (19,22,43,50), SEND entered after 4 valid cycles.
- Assert i_reset during COMPUTE and during SEND → next cycle all outputs 0, state IDLE; a subsequent full run produces correct results.

Source files
------------

// File: rtl/matmul_axis_top.sv
// Output-stationary SIZE x SIZE systolic multiplier (C = A*B) with saturating
// accumulators; the finished C matrix is streamed row-major over AXI4-Stream.
module matmul_axis_top #(
  parameter int SIZE                   = 4,
  parameter int I_BITS                 = 8,
  parameter int O_BITS                 = 16,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32
) (
  input  logic                                  i_clock,
  input  logic                                  i_reset,
  input  logic                                  i_valid,
  input  logic [I_BITS*SIZE-1:0]                i_a_full,
  input  logic [I_BITS*SIZE-1:0]                i_b_full,
  input  logic [2:0]                            rf_matrix_size,
  output logic [O_BITS*SIZE-1:0]                o_c_diag_to_buffer,
  input  logic                                  m00_axis_aclk,
  input  logic                                  m00_axis_aresetn,
  output logic                                  m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                                  m00_axis_tlast,
  input  logic                                  m00_axis_tready
);
  localparam int LOG_SIZE = $clog2(SIZE);
  localparam int IW       = 2 * LOG_SIZE + 1;
  localparam int CW       = $clog2(3 * SIZE) + 1;
  localparam int SW       = ((2 * I_BITS > O_BITS) ? 2 * I_BITS : O_BITS) + 1;
  localparam int TW       = C_M00_AXIS_TDATA_WIDTH;
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-O_BITS+1){1'b0}}, {(O_BITS-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-O_BITS+1){1'b1}}, {(O_BITS-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_COMPUTE, ST_SEND, ST_DONE} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic                      tvalid_q, tvalid_d;
  logic                      tlast_q, tlast_d;
  logic [TW-1:0]             tdata_q, tdata_d;
  logic signed [O_BITS-1:0]  acc_q [SIZE][SIZE];
  logic signed [O_BITS-1:0]  acc_d [SIZE][SIZE];
  logic signed [I_BITS-1:0]  a_q [SIZE][SIZE];
  logic signed [I_BITS-1:0]  a_d [SIZE][SIZE];
  logic signed [I_BITS-1:0]  b_q [SIZE][SIZE];
  logic signed [I_BITS-1:0]  b_d [SIZE][SIZE];
  logic signed [I_BITS-1:0]  a_in_s [SIZE][SIZE];
  logic signed [I_BITS-1:0]  b_in_s [SIZE][SIZE];
  logic                      accept_s;
  logic [3:0]                code_p1_s, n_log_s;
  logic [IW-1:0]             n_act_s, last_beat_s;
  logic [CW-1:0]             target_cnt_s;
  logic [LOG_SIZE-1:0]       row_s, col_s;
  logic signed [O_BITS-1:0]  sel_s;
  logic                      unused_s;

  // Multiply-accumulate with the sum clamped to the signed O_BITS range.
  function automatic logic signed [O_BITS-1:0] mac_f(
    input logic signed [O_BITS-1:0] acc,
    input logic signed [I_BITS-1:0] a,
    input logic signed [I_BITS-1:0] b
  );
    logic signed [SW-1:0] sum;
    sum = SW'(acc) + (SW'(a) * SW'(b));
    if (sum > SAT_MAX) begin
      mac_f = SAT_MAX[O_BITS-1:0];
    end else if (sum < SAT_MIN) begin
      mac_f = SAT_MIN[O_BITS-1:0];
    end else begin
      mac_f = sum[O_BITS-1:0];
    end
  endfunction

  assign unused_s       = m00_axis_aclk ^ m00_axis_aresetn;
  assign m00_axis_tvalid = tvalid_q;
  assign m00_axis_tdata  = tdata_q;
  assign m00_axis_tlast  = tlast_q;
  assign m00_axis_tstrb  = '1;

  // Operand wiring: edge PEs take the input lanes, inner PEs the neighbour registers.
  for (genvar r = 0; r < SIZE; r++) begin : g_row
    assign o_c_diag_to_buffer[O_BITS*r +: O_BITS] = acc_q[r][r];
    for (genvar c = 0; c < SIZE; c++) begin : g_col
      if (c == 0) begin : g_a_edge
        assign a_in_s[r][c] = i_a_full[I_BITS*r +: I_BITS];
      end else begin : g_a_fwd
        assign a_in_s[r][c] = a_q[r][c-1];
      end
      if (r == 0) begin : g_b_edge
        assign b_in_s[r][c] = i_b_full[I_BITS*c +: I_BITS];
      end else begin : g_b_fwd
        assign b_in_s[r][c] = b_q[r-1][c];
      end
    end
  end

  // Active size: N = 2^(code+1) clamped to SIZE, plus derived beat/cycle limits.
  always_comb begin
    code_p1_s = {1'b0, rf_matrix_size} + 4'd1;
    if (code_p1_s > 4'(LOG_SIZE)) begin
      n_log_s = 4'(LOG_SIZE);
    end else begin
      n_log_s = code_p1_s;
    end
    n_act_s      = IW'(1) << n_log_s;
    last_beat_s  = (IW'(1) << {n_log_s[2:0], 1'b0}) - IW'(1);
    target_cnt_s = (CW'(n_act_s) * CW'(3)) - CW'(2);
  end

  // Control FSM: count accepted cycles, then walk the beat index on handshakes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    accept_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_COMPUTE: begin
        if (i_valid) begin
          accept_s = 1'b1;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_d == target_cnt_s) begin
            state_d = ST_SEND;
          end else begin
            state_d = ST_COMPUTE;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_SEND: begin
        if (tvalid_q && m00_axis_tready) begin
          if (idx_q == last_beat_s) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // PE array next state; PEs outside the active N x N corner are held at zero.
  always_comb begin
    for (int r = 0; r < SIZE; r++) begin
      for (int c = 0; c < SIZE; c++) begin
        acc_d[r][c] = acc_q[r][c];
        a_d[r][c]   = a_q[r][c];
        b_d[r][c]   = b_q[r][c];
        if (accept_s) begin
          acc_d[r][c] = mac_f(acc_q[r][c], a_in_s[r][c], b_in_s[r][c]);
          a_d[r][c]   = a_in_s[r][c];
          b_d[r][c]   = b_in_s[r][c];
        end else begin
          acc_d[r][c] = acc_q[r][c];
        end
        if ((IW'(r) >= n_act_s) || (IW'(c) >= n_act_s)) begin
          acc_d[r][c] = '0;
        end else begin
          acc_d[r][c] = acc_d[r][c];
        end
      end
    end
  end

  // AXIS beat selection from next-state accumulators so the first beat is ready on entry.
  always_comb begin
    row_s    = LOG_SIZE'(idx_d >> n_log_s);
    col_s    = LOG_SIZE'(idx_d & (n_act_s - IW'(1)));
    sel_s    = acc_d[row_s][col_s];
    tvalid_d = (state_d == ST_SEND);
    if (tvalid_d) begin
      tdata_d = TW'(sel_s);
      tlast_d = (idx_d == last_beat_s);
    end else begin
      tdata_d = '0;
      tlast_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      for (int r = 0; r < SIZE; r++) begin
        for (int c = 0; c < SIZE; c++) begin
          acc_q[r][c] <= '0;
          a_q[r][c]   <= '0;
          b_q[r][c]   <= '0;
        end
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
      for (int r = 0; r < SIZE; r++) begin
        for (int c = 0; c < SIZE; c++) begin
          acc_q[r][c] <= acc_d[r][c];
          a_q[r][c]   <= a_d[r][c];
          b_q[r][c]   <= b_d[r][c];
        end
      end
    end
  end

endmodule

// File: tb/tb_matmul_axis_top.sv
// Randomized bench for matmul_axis_top: skewed operand streams are checked against
// a plain saturating matrix-product model, including stalls, backpressure and resets.
module tb_matmul_axis_top;
  localparam int SIZE = 4;
  localparam int IB   = 8;
  localparam int OB   = 16;
  localparam int TW   = 32;

  logic                 clk = 1'b0;
  logic                 i_reset = 1'b0;
  logic                 i_valid = 1'b0;
  logic [IB*SIZE-1:0]   i_a_full = '0;
  logic [IB*SIZE-1:0]   i_b_full = '0;
  logic [2:0]           rf_matrix_size = 3'd1;
  logic [OB*SIZE-1:0]   o_c_diag_to_buffer;
  logic                 m00_axis_tvalid;
  logic [TW-1:0]        m00_axis_tdata;
  logic [TW/8-1:0]      m00_axis_tstrb;
  logic                 m00_axis_tlast;
  logic                 m00_axis_tready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int a_m [SIZE][SIZE];
  int b_m [SIZE][SIZE];
  int c_m [SIZE][SIZE];

  always #5 clk = ~clk;

  matmul_axis_top #(.SIZE(SIZE), .I_BITS(IB), .O_BITS(OB), .C_M00_AXIS_TDATA_WIDTH(TW)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_valid(i_valid),
    .i_a_full(i_a_full), .i_b_full(i_b_full), .rf_matrix_size(rf_matrix_size),
    .o_c_diag_to_buffer(o_c_diag_to_buffer),
    .m00_axis_aclk(clk), .m00_axis_aresetn(1'b1),
    .m00_axis_tvalid(m00_axis_tvalid), .m00_axis_tdata(m00_axis_tdata),
    .m00_axis_tstrb(m00_axis_tstrb), .m00_axis_tlast(m00_axis_tlast),
    .m00_axis_tready(m00_axis_tready)
  );

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // C = A*B over the active N x N corner, saturating after every added term.
  task automatic build_model(input int n);
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) begin
        c_m[r][c] = 0;
        if (r < n && c < n)
          for (int k = 0; k < n; k++) c_m[r][c] = sat16(c_m[r][c] + a_m[r][k] * b_m[k][c]);
      end
  endtask

  task automatic fill(input int kind);
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) begin
        case (kind)
          0: begin a_m[r][c] = (r == c) ? 1 : 0; b_m[r][c] = 3; end
          1: begin a_m[r][c] = c + 1; b_m[r][c] = c + 1; end
          2: begin a_m[r][c] = 127; b_m[r][c] = 127; end
          3: begin a_m[r][c] = -128; b_m[r][c] = 127; end
          5: begin a_m[r][c] = 0; b_m[r][c] = 0; end
          default: begin
            a_m[r][c] = int'($urandom_range(0, 255)) - 128;
            b_m[r][c] = int'($urandom_range(0, 255)) - 128;
          end
        endcase
      end
    if (kind == 5) begin
      a_m[0][0] = 1; a_m[0][1] = 2; a_m[1][0] = 3; a_m[1][1] = 4;
      b_m[0][0] = 5; b_m[0][1] = 6; b_m[1][0] = 7; b_m[1][1] = 8;
    end
  endtask

  task automatic drive_noise();
    i_a_full = IB*SIZE'({$urandom, $urandom});
    i_b_full = IB*SIZE'({$urandom, $urandom});
  endtask

  // Skewed lanes for valid step t: row r delayed r, column c delayed c; unused lanes get noise.
  task automatic drive_step(input int t, input int n);
    int v;
    for (int l = 0; l < SIZE; l++) begin
      if (l >= n) v = int'($urandom_range(0, 255));
      else if (t - l >= 0 && t - l < n) v = a_m[l][t-l];
      else v = 0;
      i_a_full[IB*l +: IB] = IB'(v);
      if (l >= n) v = int'($urandom_range(0, 255));
      else if (t - l >= 0 && t - l < n) v = b_m[t-l][l];
      else v = 0;
      i_b_full[IB*l +: IB] = IB'(v);
    end
  endtask

  task automatic check_diag(input string tag, input int n);
    for (int k = 0; k < SIZE; k++)
      check_val(tag, longint'($signed(o_c_diag_to_buffer[OB*k +: OB])), (k < n) ? c_m[k][k] : 0);
  endtask

  // Reset with valid data asserted to show reset wins over everything else.
  task automatic do_reset();
    i_reset = 1'b1; i_valid = 1'b1; m00_axis_tready = 1'b1; drive_noise();
    @(posedge clk); #1;
    i_reset = 1'b0; i_valid = 1'b0;
    check_val("rst_diag", longint'(o_c_diag_to_buffer), 0);
    check_val("rst_tvalid", longint'(m00_axis_tvalid), 0);
    check_val("rst_tlast", longint'(m00_axis_tlast), 0);
    check_val("rst_tdata", longint'(m00_axis_tdata), 0);
    check_val("tstrb", longint'(m00_axis_tstrb), 15);
  endtask

  // abort: 0 full run, 1 reset mid-compute, 2 reset mid-send.
  task automatic run_case(input int code, input int kind, input bit stall, input bit rand_rdy, input int abort);
    int n, steps, beat, cyc, tl_cnt;
    bit hs;
    n = 1 << (code + 1);
    if (n > SIZE) n = SIZE;
    fill(kind);
    build_model(n);
    rf_matrix_size = 3'(code);
    do_reset();
    steps = 3 * n - 2;
    for (int t = 0; t < steps; t++) begin
      if (stall) begin
        repeat ($urandom_range(0, 2)) begin
          i_valid = 1'b0; drive_noise();
          @(posedge clk); #1;
        end
      end
      drive_step(t, n);
      i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      if (t == 0)
        check_val("first_mac", longint'($signed(o_c_diag_to_buffer[OB-1:0])), a_m[0][0] * b_m[0][0]);
      check_val("send_entry", longint'(m00_axis_tvalid), (t == steps - 1) ? 1 : 0);
      if (abort == 1 && t == steps / 2) begin
        do_reset();
        return;
      end
    end
    check_diag("diag", n);
    beat = 0; cyc = 0; tl_cnt = 0;
    while (beat < n * n && cyc < 400) begin
      m00_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      i_valid = 1'($urandom_range(0, 1));
      drive_noise();
      check_val("tvalid", longint'(m00_axis_tvalid), 1);
      check_val("tdata", longint'($signed(m00_axis_tdata)), c_m[beat / n][beat % n]);
      check_val("tlast", longint'(m00_axis_tlast), (beat == n * n - 1) ? 1 : 0);
      hs = m00_axis_tready && m00_axis_tvalid;
      if (hs && m00_axis_tlast) tl_cnt++;
      @(posedge clk); #1;
      cyc++;
      if (hs) beat++;
      if (abort == 2 && beat == 3) begin
        do_reset();
        return;
      end
    end
    check_val("beat_count", beat, n * n);
    check_val("tlast_count", tl_cnt, 1);
    m00_axis_tready = 1'b1; i_valid = 1'b0;
    repeat (3) begin
      check_val("done_tvalid", longint'(m00_axis_tvalid), 0);
      @(posedge clk); #1;
    end
    check_diag("done_diag", n);
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();
    run_case(1, 0, 1'b0, 1'b0, 0);   // A = I, B = 3
    run_case(1, 1, 1'b0, 1'b0, 0);   // rows [1,2,3,4]
    run_case(1, 1, 1'b1, 1'b1, 0);   // same with stalls and backpressure
    run_case(1, 2, 1'b0, 1'b0, 0);   // positive saturation
    run_case(1, 3, 1'b1, 1'b0, 0);   // negative saturation
    run_case(0, 5, 1'b0, 1'b1, 0);   // N = 2 fixed example
    run_case(2, 4, 1'b1, 1'b1, 0);   // code 010 clamps to SIZE
    run_case(1, 4, 1'b0, 1'b0, 1);   // reset mid-compute
    run_case(1, 4, 1'b1, 1'b1, 0);
    run_case(1, 4, 1'b0, 1'b1, 2);   // reset mid-send
    run_case(0, 4, 1'b1, 1'b1, 0);
    for (int i = 0; i < 6; i++)
      run_case(int'($urandom_range(0, 3)), 4, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
